// File: rtl/sparse_pkg.sv
// Shared types and helpers for the sparse convolution datapath blocks.
package sparse_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        SETTLE = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    function automatic int unsigned win_depth(input int unsigned row_length,
                                              input int unsigned filter_size);
        return row_length - filter_size + 1;
    endfunction

    // The offset is only formed after the ordering test, so it never wraps.
    function automatic logic hit_test(input int unsigned in_idx,
                                      input int unsigned w_idx,
                                      input int unsigned depth);
        return (in_idx >= w_idx) && ((in_idx - w_idx) <= (depth - 1));
    endfunction

endpackage

// File: rtl/sparse_mac_acc_sat_add.sv
// Accumulator adder: zero-extends the addend, reports carry-out, and either
// clamps to all-ones or wraps depending on SATURATE.
module sat_add #(
    parameter int unsigned ACC_W    = 20,
    parameter int unsigned IN_W     = 16,
    parameter bit          SATURATE = 1'b1
) (
    input  logic [ACC_W-1:0] a,
    input  logic [IN_W-1:0]  b,
    output logic [ACC_W-1:0] sum_c,
    output logic             ovf_c
);

    localparam int unsigned EXT_W = ACC_W + 1;

    logic [EXT_W-1:0] full;

    assign full  = {1'b0, a} + EXT_W'(b);
    assign ovf_c = full[ACC_W];

    always_comb begin
        sum_c = full[ACC_W-1:0];
        if (SATURATE && ovf_c) begin
            sum_c = '1;
        end
    end

endmodule

// File: rtl/sparse_mac_acc.sv
// Sparse MAC accumulator: index-matched activation/weight pairs are multiplied
// into a per-offset bank, which is drained in offset order on flush.
module sparse_mac_acc
    import sparse_pkg::*;
#(
    parameter int unsigned ROW_LENGTH  = 28,
    parameter int unsigned FILTER_SIZE = 5,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned IDX_W       = 8,
    parameter int unsigned ACC_W       = 20,
    parameter bit          SATURATE    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_index,
    input  logic [DATA_W-1:0] w_data,
    input  logic [IDX_W-1:0]  w_index,
    input  logic              flush,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              ovf
);

    localparam int unsigned N      = win_depth(ROW_LENGTH, FILTER_SIZE);
    localparam int unsigned PTR_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PROD_W = 2 * DATA_W;

    state_e            state;
    state_e            state_nxt;
    logic              settle_cnt;
    logic [PTR_W-1:0]  ptr;
    logic [ACC_W-1:0]  acc [N];

    logic              s1_valid;
    logic              s1_hit;
    logic [PTR_W-1:0]  s1_off;
    logic [PROD_W-1:0] s1_prod;

    logic              in_fire;
    logic              out_fire;
    logic              last_entry;
    logic              hit_c;
    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;

    assign in_ready   = (state == ACCUM);
    assign busy       = (state != ACCUM);
    assign out_valid  = (state == DRAIN);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign last_entry = (ptr == PTR_W'(N - 1));
    assign hit_c      = hit_test(32'(in_index), 32'(w_index), N);

    // Drain outputs are masked to zero outside DRAIN.
    assign out_data  = out_valid ? acc[ptr] : '0;
    assign out_index = out_valid ? IDX_W'(ptr) : '0;
    assign out_last  = out_valid && last_entry;

    sat_add #(
        .ACC_W    (ACC_W),
        .IN_W     (PROD_W),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .a     (acc[s1_off]),
        .b     (s1_prod),
        .sum_c (add_sum),
        .ovf_c (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ACCUM:   if (flush) state_nxt = SETTLE;
            SETTLE:  if (settle_cnt) state_nxt = DRAIN;
            DRAIN:   if (out_fire && last_entry) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // S1: register product, offset and hit for an accepted pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_off   <= '0;
            s1_prod  <= '0;
        end else begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_hit  <= hit_c;
                s1_off  <= hit_c ? PTR_W'(in_index - w_index) : '0;
                s1_prod <= PROD_W'(in_data) * PROD_W'(w_data);
            end
        end
    end

    // SETTLE lasts two cycles, long enough for S1 and S2 to empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= 1'b0;
        end else begin
            settle_cnt <= (state == SETTLE) ? ~settle_cnt : 1'b0;
        end
    end

    // S2 read-modify-write and drain-side clearing share the bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) begin
                acc[i] <= '0;
            end
            ptr <= '0;
            ovf <= 1'b0;
        end else begin
            if (s1_valid && s1_hit) begin
                acc[s1_off] <= add_sum;
                if (add_ovf) begin
                    ovf <= 1'b1;
                end
            end
            if (out_fire) begin
                acc[ptr] <= '0;
                if (last_entry) begin
                    ptr <= '0;
                    ovf <= 1'b0;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sparse_mac_acc.sv
// Self-checking bench for sparse_mac_acc: a saturating and a wrapping instance
// share stimulus and are compared against an arithmetic model of the bank.
module tb_sparse_mac_acc;

    localparam int    N    = 24;
    localparam longint MAXV = 1048575;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [7:0]  in_index;
    logic [7:0]  w_data;
    logic [7:0]  w_index;
    logic        flush;
    logic        out_ready;

    logic        in_ready,  busy,  out_valid,  out_last,  ovf;
    logic [19:0] out_data;
    logic [7:0]  out_index;
    logic        w_in_ready, w_busy, w_out_valid, w_out_last, w_ovf;
    logic [19:0] w_out_data;
    logic [7:0]  w_out_index;

    longint m_sat  [N];
    longint m_wrap [N];
    bit     m_ovf_sat;
    bit     m_ovf_wrap;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sparse_mac_acc #(.SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_index(in_index), .w_data(w_data), .w_index(w_index),
        .flush(flush), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last), .ovf(ovf)
    );

    sparse_mac_acc #(.SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_data(in_data), .in_index(in_index), .w_data(w_data), .w_index(w_index),
        .flush(flush), .busy(w_busy), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_data(w_out_data), .out_index(w_out_index), .out_last(w_out_last), .ovf(w_ovf)
    );

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_sat[i]  = 0;
            m_wrap[i] = 0;
        end
        m_ovf_sat  = 0;
        m_ovf_wrap = 0;
    endtask

    task automatic model_pair(input int a, input int ai, input int w, input int wi);
        int     off;
        longint p;
        if (ai >= wi && (ai - wi) <= N - 1) begin
            off = ai - wi;
            p   = longint'(a) * longint'(w);
            if (m_sat[off] + p > MAXV) begin
                m_sat[off] = MAXV;
                m_ovf_sat  = 1;
            end else begin
                m_sat[off] = m_sat[off] + p;
            end
            if (m_wrap[off] + p > MAXV) m_ovf_wrap = 1;
            m_wrap[off] = (m_wrap[off] + p) % (MAXV + 1);
        end
    endtask

    task automatic send(input int a, input int ai, input int w, input int wi, input bit fl);
        in_valid = 1'b1;
        in_data  = 8'(a);
        in_index = 8'(ai);
        w_data   = 8'(w);
        w_index  = 8'(wi);
        flush    = fl;
        @(posedge clk); #1;
        model_pair(a, ai, w, wi);
        in_valid = 1'b0;
        flush    = 1'b0;
        if (fl) begin
            n_checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1 || w_in_ready !== 1'b0)
                $display("FAIL settle_entry: in_ready=%b busy=%b expected 0/1", in_ready, busy);
            else n_pass++;
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL settle_flush: in_ready=%b busy=%b expected 0/1", in_ready, busy);
        else n_pass++;
    endtask

    task automatic drain_check(input string tag, input bit rand_ready);
        int got;
        int cyc;
        bit rdy;
        got = 0;
        cyc = 0;
        while (!out_valid && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (ovf !== m_ovf_sat || w_ovf !== m_ovf_wrap)
            $display("FAIL %s ovf_pre: got sat=%b wrap=%b expected %b/%b", tag, ovf, w_ovf, m_ovf_sat, m_ovf_wrap);
        else n_pass++;
        while (got < N && cyc < 400) begin
            rdy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            out_ready = rdy;
            n_checks++;
            if (out_valid !== 1'b1 || out_index !== 8'(got) || out_data !== 20'(m_sat[got])
                || out_last !== (got == N - 1) || in_ready !== 1'b0 || busy !== 1'b1)
                $display("FAIL %s sat_entry: v=%b idx=%0d data=%0d last=%b rdy=%b expected idx=%0d data=%0d last=%b",
                         tag, out_valid, out_index, out_data, out_last, in_ready, got, m_sat[got], got == N - 1);
            else n_pass++;
            n_checks++;
            if (w_out_valid !== 1'b1 || w_out_index !== 8'(got) || w_out_data !== 20'(m_wrap[got])
                || w_out_last !== (got == N - 1))
                $display("FAIL %s wrap_entry: v=%b idx=%0d data=%0d expected idx=%0d data=%0d",
                         tag, w_out_valid, w_out_index, w_out_data, got, m_wrap[got]);
            else n_pass++;
            @(posedge clk); #1;
            cyc++;
            if (rdy) got++;
        end
        out_ready = 1'b0;
        if (got < N) begin
            n_checks++;
            $display("FAIL %s drain_timeout: drained %0d entries, expected %0d", tag, got, N);
        end
        n_checks++;
        if (ovf !== 1'b0 || w_ovf !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL %s post_drain: ovf=%b/%b busy=%b in_ready=%b out_valid=%b expected 0/0 0 1 0",
                     tag, ovf, w_ovf, busy, in_ready, out_valid);
        else n_pass++;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 20'd0 || out_index !== 8'd0 || out_last !== 1'b0
            || ovf !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_state: v=%b d=%0d i=%0d l=%b ovf=%b busy=%b in_ready=%b expected 0 0 0 0 0 0 1",
                     out_valid, out_data, out_index, out_last, ovf, busy, in_ready);
        else n_pass++;
    endtask

    task automatic test_single_hit();
        send(3, 10, 4, 7, 1'b0);
        do_flush();
        drain_check("single_hit", 1'b0);
    endtask

    task automatic test_window_edges();
        send(9, 30, 7, 7, 1'b0);
        send(11, 31, 13, 7, 1'b0);
        send(17, 5, 19, 7, 1'b0);
        do_flush();
        drain_check("window_edges", 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) send(255, 40, 255, 40, 1'b0);
        do_flush();
        drain_check("back_to_back", 1'b0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 17; i++) send(255, 12, 255, 7, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ovf !== 1'b1 || w_ovf !== 1'b1)
            $display("FAIL saturation_ovf: got sat=%b wrap=%b expected 1/1", ovf, w_ovf);
        else n_pass++;
        do_flush();
        drain_check("saturation", 1'b0);
    endtask

    task automatic test_flush_backpressure();
        send(21, 8, 5, 2, 1'b0);
        send(200, 50, 100, 27, 1'b0);
        send(77, 15, 66, 15, 1'b1);
        drain_check("flush_pair", 1'b1);
        do_flush();
        drain_check("second_flush", 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                send(int'($urandom_range(0, 255)), int'($urandom_range(0, 40)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 20)), 1'b0);
            end else begin
                @(posedge clk); #1;
            end
        end
        send(int'($urandom_range(0, 255)), int'($urandom_range(0, 30)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 10)), 1'b1);
        drain_check("random", 1'b1);
    endtask

    task automatic test_reset_mid_drain();
        int cyc;
        send(50, 9, 60, 2, 1'b0);
        send(255, 20, 255, 0, 1'b0);
        do_flush();
        cyc = 0;
        while (!out_valid && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_index !== 8'd7 || out_valid !== 1'b1 || out_data !== 20'(m_sat[7]))
            $display("FAIL mid_drain_entry7: idx=%0d v=%b data=%0d expected 7 1 %0d", out_index, out_valid, out_data, m_sat[7]);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || ovf !== 1'b0 || w_out_valid !== 1'b0)
            $display("FAIL mid_drain_reset: out_valid=%b busy=%b in_ready=%b ovf=%b expected 0 0 1 0",
                     out_valid, busy, in_ready, ovf);
        else n_pass++;
        do_flush();
        drain_check("after_reset", 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_index  = '0;
        w_data    = '0;
        w_index   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single_hit();
        test_window_edges();
        test_back_to_back();
        test_saturation();
        test_flush_backpressure();
        test_random();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
